// File: rtl/sram_ctrl.sv
// sram_ctrl: burst initiator for a synchronous single-port SRAM.
// Write bursts follow wr_valid, read bursts issue every cycle and return data two cycles after issue.
module sram_ctrl #(
  parameter int data_width = 8,
  parameter int mem_width  = 1024,
  parameter int addr_width = 10,
  parameter int len_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [addr_width-1:0] cmd_addr,
  input  logic [len_width-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [data_width-1:0] wr_data,
  output logic                  rd_valid,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  err,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic [addr_width-1:0] sram_addr,
  output logic [data_width-1:0] sram_din,
  input  logic [data_width-1:0] sram_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_DRAIN} state_t;

  localparam logic [addr_width:0]   LP_MEM_LIM  = (addr_width+1)'(mem_width);
  localparam logic [addr_width-1:0] LP_ADDR_TOP = addr_width'(mem_width - 1);

  state_t                r_state, w_state_nxt;
  logic [addr_width-1:0] r_addr, r_addr_hold;
  logic [len_width-1:0]  r_cnt;
  logic [data_width-1:0] r_din_hold, r_rd_data;
  logic                  r_vld_p1, r_last_p1;
  logic                  r_rd_valid, r_rd_last, r_done, r_err;
  logic                  w_cmd_acc, w_oob, w_wr_beat, w_rd_iss, w_access, w_last_beat;

  // Bursts wrap from the top word back to address 0.
  function automatic logic [addr_width-1:0] f_addr_inc(input logic [addr_width-1:0] a);
    return (a == LP_ADDR_TOP) ? '0 : a + 1'b1;
  endfunction

  assign w_oob       = ({1'b0, cmd_addr} >= LP_MEM_LIM);
  assign w_cmd_acc   = (r_state == ST_IDLE) && cmd_valid;
  assign w_wr_beat   = (r_state == ST_WR) && wr_valid;
  assign w_rd_iss    = (r_state == ST_RD);
  assign w_access    = w_wr_beat || w_rd_iss;
  assign w_last_beat = (r_cnt == '0);

  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign rd_data  = r_rd_data;
  assign done     = r_done;
  assign err      = r_err;

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    sram_cs     = w_access;
    sram_we     = w_wr_beat;
    sram_oe     = w_rd_iss;
    sram_addr   = w_access ? r_addr : r_addr_hold;
    sram_din    = w_wr_beat ? wr_data : r_din_hold;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (w_cmd_acc && !w_oob) w_state_nxt = cmd_we ? ST_WR : ST_RD;
      end
      ST_WR: begin
        wr_ready = 1'b1;
        if (w_wr_beat && w_last_beat) w_state_nxt = ST_IDLE;
      end
      ST_RD: begin
        if (w_last_beat) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_vld_p1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_addr_hold <= '0;
      r_din_hold  <= '0;
      r_vld_p1    <= 1'b0;
      r_last_p1   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_acc) begin
        r_addr <= cmd_addr;
        r_cnt  <= cmd_len;
      end else if (w_access) begin
        r_addr <= f_addr_inc(r_addr);
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_access)  r_addr_hold <= r_addr;
      if (w_wr_beat) r_din_hold  <= wr_data;
      // p1: SRAM is presenting data for the read issued last cycle
      r_vld_p1  <= w_rd_iss;
      r_last_p1 <= w_rd_iss && w_last_beat;
      // output stage: registered SRAM data
      r_rd_valid <= r_vld_p1;
      r_rd_last  <= r_last_p1;
      if (r_vld_p1) r_rd_data <= sram_dout;
      r_done <= (w_wr_beat && w_last_beat) || r_last_p1 || (w_cmd_acc && w_oob);
      r_err  <= w_cmd_acc && w_oob;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: random burst traffic against a behavioural SRAM and an array-based reference of memory contents.
// Address bus is one bit wider than the memory so out-of-range start addresses can be driven.
module tb_sram_ctrl;

  localparam int DW   = 8;
  localparam int AW   = 11;
  localparam int LW   = 8;
  localparam int MEMW = 1024;

  logic          clk = 1'b0;
  logic          rst, clr;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_last, done, err;
  logic [DW-1:0] rd_data;
  logic          sram_cs, sram_we, sram_oe;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem  [0:MEMW-1];
  logic [DW-1:0] pat_q[$];

  typedef struct {int c; logic [AW-1:0] a; logic we; logic oe; logic [DW-1:0] d;} acc_t;
  typedef struct {int c; logic [DW-1:0] d; logic last;} rd_t;
  typedef struct {int c; logic err;} dn_t;
  acc_t acc_q[$];
  rd_t  rd_q[$];
  dn_t  done_q[$];

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          mon_en = 1'b0;
  logic [AW-1:0] hold_a = '0;
  logic [DW-1:0] hold_d = '0;

  sram_ctrl #(.data_width(DW), .mem_width(MEMW), .addr_width(AW), .len_width(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM with registered output.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= '0;
      sram_dout <= '0;
    end else if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= sram_din;
      if (sram_oe) sram_dout <= sram_mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor samples just before each rising edge.
  always @(negedge clk) begin
    acc_t e;
    rd_t  r;
    dn_t  d;
    #4;
    if (mon_en) begin
      check_eq("we_and_oe", 32'(sram_we & sram_oe), 0);
      check_eq("strobe_wo_cs", 32'(~sram_cs & (sram_we | sram_oe)), 0);
      check_eq("err_wo_done", 32'(err & ~done), 0);
      check_eq("last_wo_valid", 32'(rd_last & ~rd_valid), 0);
      if (sram_cs) begin
        e.c = cyc; e.a = sram_addr; e.we = sram_we; e.oe = sram_oe; e.d = sram_din;
        acc_q.push_back(e);
        hold_a = sram_addr;
        if (sram_we) hold_d = sram_din;
      end else begin
        check_eq("addr_hold", sram_addr, hold_a);
        check_eq("din_hold", sram_din, hold_d);
      end
      if (rd_valid) begin
        r.c = cyc; r.d = rd_data; r.last = rd_last;
        rd_q.push_back(r);
      end
      if (done) begin
        d.c = cyc; d.err = err;
        done_q.push_back(d);
      end
    end
    if (rst) begin
      hold_a = '0;
      hold_d = '0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic we, input int addr, input int len);
    step();
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    #1 check_eq("cmd_ready_idle", cmd_ready, 1);
    acc_q.delete();
    rd_q.delete();
    done_q.delete();
  endtask

  task automatic do_write(input int addr, input int len, input int min_st, input int max_st);
    logic [DW-1:0] d[$];
    int beat_c[$];
    int acc_c, cur, ns;
    issue_cmd(1'b1, addr, len);
    acc_c = cyc;
    step();
    cmd_valid = 1'b0;
    cur = acc_c + 1;
    for (int i = 0; i <= len; i++) begin
      ns = (i == 0) ? 0 : int'($urandom_range(max_st, min_st));
      repeat (ns) begin
        wr_valid = 1'b0;
        step();
      end
      wr_valid = 1'b1;
      wr_data  = (i < pat_q.size()) ? pat_q[i] : DW'($urandom);
      d.push_back(wr_data);
      cur += ns;
      beat_c.push_back(cur);
      cur++;
      #1 check_eq("wr_ready", wr_ready, 1);
      step();
    end
    wr_valid = 1'b0;
    pat_q.delete();
    repeat (2) step();
    check_eq("wr_count", acc_q.size(), len + 1);
    for (int i = 0; i <= len && i < acc_q.size(); i++) begin
      check_eq("wr_addr", acc_q[i].a, (addr + i) % MEMW);
      check_eq("wr_we", acc_q[i].we, 1);
      check_eq("wr_oe", acc_q[i].oe, 0);
      check_eq("wr_din", acc_q[i].d, d[i]);
      check_eq("wr_cycle", acc_q[i].c, beat_c[i]);
    end
    for (int i = 0; i <= len; i++) exp_mem[(addr + i) % MEMW] = d[i];
    check_eq("wr_done_count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check_eq("wr_done_cycle", done_q[0].c, beat_c[len] + 1);
      check_eq("wr_done_err", done_q[0].err, 0);
    end
  endtask

  task automatic do_read(input int addr, input int len, input logic hold);
    int acc_c, k;
    issue_cmd(1'b0, addr, len);
    acc_c = cyc;
    step();
    if (!hold) cmd_valid = 1'b0;
    k = 0;
    while (done_q.size() == 0 && k < len + 20) begin
      if (hold) check_eq("cmd_ready_busy", cmd_ready, 0);
      step();
      k++;
    end
    if (done_q.size() == 0) begin
      check_eq("rd_done_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      check_eq("idle_after_done", cmd_ready, 1);
      cmd_valid = 1'b0;
      check_eq("rd_done_count", done_q.size(), 1);
      check_eq("rd_done_err", done_q[0].err, 0);
    end
    step();
    check_eq("rd_issue_count", acc_q.size(), len + 1);
    for (int i = 0; i <= len && i < acc_q.size(); i++) begin
      check_eq("rd_addr", acc_q[i].a, (addr + i) % MEMW);
      check_eq("rd_oe", acc_q[i].oe, 1);
      check_eq("rd_we", acc_q[i].we, 0);
      check_eq("rd_issue_cycle", acc_q[i].c, acc_c + 1 + i);
    end
    check_eq("rd_beat_count", rd_q.size(), len + 1);
    for (int i = 0; i <= len && i < rd_q.size(); i++) begin
      check_eq("rd_data", rd_q[i].d, exp_mem[(addr + i) % MEMW]);
      check_eq("rd_beat_cycle", rd_q[i].c, acc_c + 3 + i);
      check_eq("rd_last", rd_q[i].last, (i == len) ? 1 : 0);
    end
    if (done_q.size() > 0 && rd_q.size() > 0)
      check_eq("rd_done_with_last", done_q[0].c, rd_q[rd_q.size()-1].c);
  endtask

  task automatic do_err(input int addr);
    int acc_c;
    issue_cmd(1'($urandom_range(0, 1)), addr, int'($urandom_range(0, 255)));
    acc_c = cyc;
    step();
    cmd_valid = 1'b0;
    check_eq("err_stays_idle", cmd_ready, 1);
    repeat (2) step();
    check_eq("err_no_access", acc_q.size(), 0);
    check_eq("err_done_count", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check_eq("err_done_cycle", done_q[0].c, acc_c + 1);
      check_eq("err_flag", done_q[0].err, 1);
    end
  endtask

  task automatic do_reset_mid_read(input int addr);
    int k;
    issue_cmd(1'b0, addr, 7);
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (acc_q.size() < 2 && k < 10) begin
      step();
      k++;
    end
    check_eq("rst_two_issues", acc_q.size(), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_cs", sram_cs, 0);
    done_q.delete();
    repeat (4) step();
    check_eq("rst_no_done", done_q.size(), 0);
    do_read(addr, 0, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r;
    rst = 1'b1; clr = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < MEMW; i++) exp_mem[i] = '0;
    repeat (3) @(posedge clk);
    step();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_last", rd_last, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_sram_strobes", {sram_cs, sram_we, sram_oe}, 0);
    check_eq("rst_sram_addr", sram_addr, 0);
    check_eq("rst_sram_din", sram_din, 0);
    rst = 1'b0; clr = 1'b0; mon_en = 1'b1;

    for (int i = 0; i < 4; i++) pat_q.push_back(DW'(8'hA0 + i));
    do_write(16'h010, 3, 0, 0);
    do_read(16'h010, 3, 1'b0);

    for (int i = 0; i < 4; i++) pat_q.push_back(DW'(8'h11 * (i + 1)));
    do_write(1022, 3, 0, 0);
    do_read(1022, 3, 1'b0);

    do_write(16'h200, 1, 3, 3);
    do_read(16'h200, 1, 1'b0);

    do_err(1024);
    do_err(2047);
    do_read(16'h010, 3, 1'b1);

    do_reset_mid_read(16'h010);

    a = int'($urandom_range(0, MEMW - 1));
    do_write(a, 255, 0, 0);
    do_read(a, 255, 1'b0);

    for (int it = 0; it < 16; it++) begin
      r = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, MEMW - 1));
      if (r == 0)     do_err(MEMW + int'($urandom_range(0, MEMW - 1)));
      else if (r < 5) do_write(a, int'($urandom_range(0, 20)), 0, 2);
      else            do_read(a, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
